// File: rtl/femul_arbiter.sv
// rtl/femul_arbiter.sv - round-robin arbiter sharing one femul among NREQ requesters
// One operation in flight: IDLE grants, ISSUE pulses mul_start, WAIT for mul_done, RESP holds result.
module femul_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*255-1:0]   req_a,
  input  logic [NREQ*255-1:0]   req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [254:0]          rsp_data,
  input  logic                  rsp_ready,
  output logic                  mul_start,
  output logic [254:0]          mul_a,
  output logic [254:0]          mul_b,
  input  logic                  mul_done,
  input  logic [254:0]          mul_out,
  output logic                  busy,
  output logic                  err_spurious,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_rsp_id;
  logic [254:0]     r_mul_a;
  logic [254:0]     r_mul_b;
  logic [254:0]     r_rsp_data;
  logic             r_err;
  logic [15:0]      r_op_count;

  logic             w_found;
  logic [1:0]       w_idx;
  logic [NREQ-1:0]  w_grant;
  logic [254:0]     w_sel_a;
  logic [254:0]     w_sel_b;
  logic             w_accept;
  logic             w_rsp_hs;

  // Cyclic search starting at r_rr_ptr; inner loop keeps every index constant.
  always_comb begin : p_grant
    int pos;
    w_found = 1'b0;
    w_idx   = 2'd0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(r_rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && (i == pos) && req_valid[i]) begin
          w_found = 1'b1;
          w_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_grant[i] = w_found && (int'(w_idx) == i);
      if (w_grant[i]) begin
        w_sel_a = req_a[i*255 +: 255];
        w_sel_b = req_b[i*255 +: 255];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_next = S_ISSUE;
      S_ISSUE:                w_next = S_WAIT;
      S_WAIT:  if (mul_done)  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    mul_start = (r_state == S_ISSUE);
    rsp_valid = (r_state == S_RESP);
    req_ready = ((r_state == S_IDLE) && !reset) ? w_grant : '0;
  end

  // A done pulse outside WAIT only raises the sticky error; nothing else moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr   <= 2'd0;
      r_rsp_id   <= 2'd0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
      r_op_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
        r_rsp_id <= w_idx;
      end
      if ((r_state == S_WAIT) && mul_done) r_rsp_data <= mul_out;
      if (mul_done && (r_state != S_WAIT)) r_err <= 1'b1;
      if (w_rsp_hs) begin
        r_rsp_data <= '0;
        r_rr_ptr   <= (int'(r_rsp_id) == NREQ - 1) ? 2'd0 : r_rsp_id + 2'd1;
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign err_spurious = r_err;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_femul_arbiter.sv
// tb/tb_femul_arbiter.sv - randomized bench for femul_arbiter against a behavioural model
// The femul itself is modelled inline with wide modular arithmetic.
module tb_femul_arbiter;
  localparam int NREQ = 3;
  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*255-1:0] req_a = '0;
  logic [NREQ*255-1:0] req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [254:0]        rsp_data;
  logic                rsp_ready = 1'b0;
  logic                mul_start;
  logic [254:0]        mul_a;
  logic [254:0]        mul_b;
  logic                mul_done = 1'b0;
  logic [254:0]        mul_out = '0;
  logic                busy;
  logic                err_spurious;
  logic [15:0]         op_count;

  int n_checks = 0;
  int n_errors = 0;
  int m_ptr    = 0;
  int m_count  = 0;
  bit m_err    = 1'b0;

  femul_arbiter #(.NREQ(NREQ)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_out(mul_out),
    .busy(busy), .err_spurious(err_spurious), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] p;
    p = {255'd0, a} * {255'd0, b};
    p = p % {255'd0, P};
    return p[254:0];
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[254:0];
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [254:0] a, input logic [254:0] b);
    req_a[i*255 +: 255] = a;
    req_b[i*255 +: 255] = b;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '1;
    #1 check("ready_in_reset", 255'(req_ready), 255'd0);
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    m_ptr = 0; m_count = 0; m_err = 1'b0;
  endtask

  // One complete operation; want/use_want adds a fixed-constant result check.
  task automatic do_op(input logic [NREQ-1:0] mask, input int lat, input int bp,
                       input bit spur, input logic [254:0] want, input bit use_want);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [254:0] ea, eb, exp;
    @(negedge clock);
    req_valid = mask;
    #1;
    g = model_grant(mask);
    for (int i = 0; i < NREQ; i++) exp_rdy[i] = (i == g);
    check("req_ready", 255'(req_ready), 255'(exp_rdy));
    if (g < 0) begin
      req_valid = '0;
      return;
    end
    ea  = req_a[g*255 +: 255];
    eb  = req_b[g*255 +: 255];
    exp = fmul(ea, eb);
    @(negedge clock);
    check("issue_start", 255'(mul_start), 255'd1);
    check("issue_ready", 255'(req_ready), 255'd0);
    req_valid = '0;
    @(negedge clock);
    check("wait_start", 255'(mul_start), 255'd0);
    check("mul_a", mul_a, ea);
    check("mul_b", mul_b, eb);
    repeat (lat) @(negedge clock);
    check("wait_norsp", 255'(rsp_valid), 255'd0);
    mul_done = 1'b1;
    mul_out  = fmul(mul_a, mul_b);
    @(negedge clock);
    mul_done = 1'b0;
    check("rsp_valid", 255'(rsp_valid), 255'd1);
    check("rsp_data", rsp_data, exp);
    check("rsp_id", 255'(rsp_id), 255'(g));
    if (use_want) check("rsp_const", rsp_data, want);
    for (int i = 0; i < bp; i++) begin
      req_valid = mask;
      if (spur && i == 0) begin
        mul_done = 1'b1;
        mul_out  = rnd255();
        m_err    = 1'b1;
      end
      #1 check("bp_ready", 255'(req_ready), 255'd0);
      @(negedge clock);
      mul_done = 1'b0;
      check("bp_valid", 255'(rsp_valid), 255'd1);
      check("bp_data", rsp_data, exp);
      check("bp_id", 255'(rsp_id), 255'(g));
      check("bp_start", 255'(mul_start), 255'd0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    m_count = (m_count + 1) % 65536;
    m_ptr   = (g + 1) % NREQ;
    check("done_busy", 255'(busy), 255'd0);
    check("done_valid", 255'(rsp_valid), 255'd0);
    check("done_data", rsp_data, 255'd0);
    check("op_count", 255'(op_count), 255'(m_count));
    check("err_sticky", 255'(err_spurious), 255'(m_err));
  endtask

  initial begin
    do_reset();
    check("rst_busy", 255'(busy), 255'd0);
    check("rst_valid", 255'(rsp_valid), 255'd0);
    check("rst_data", rsp_data, 255'd0);
    check("rst_id", 255'(rsp_id), 255'd0);
    check("rst_mul_a", mul_a, 255'd0);
    check("rst_mul_b", mul_b, 255'd0);
    check("rst_start", 255'(mul_start), 255'd0);
    check("rst_err", 255'(err_spurious), 255'd0);
    check("rst_count", 255'(op_count), 255'd0);

    set_ops(0, 255'd1 << 128, 255'd1 << 128);
    do_op(3'b001, 2, 0, 1'b0, 255'h26, 1'b1);

    do_reset();
    set_ops(0, {255{1'b1}}, 255'd1);
    set_ops(1, 255'd1 << 254, 255'd2);
    do_op(3'b011, 1, 5, 1'b0, 255'h12, 1'b1);
    do_op(3'b011, 0, 0, 1'b0, 255'd19, 1'b1);
    do_op(3'b011, 3, 1, 1'b0, 255'h12, 1'b1);

    @(negedge clock);
    mul_done = 1'b1;
    @(negedge clock);
    mul_done = 1'b0;
    m_err = 1'b1;
    check("spur_err", 255'(err_spurious), 255'd1);
    check("spur_busy", 255'(busy), 255'd0);
    check("spur_valid", 255'(rsp_valid), 255'd0);
    repeat (2) @(negedge clock);
    check("spur_hold", 255'(err_spurious), 255'd1);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, rnd255(), rnd255());
      do_op(NREQ'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 255'd0, 1'b0);
    end

    set_ops(0, rnd255(), rnd255());
    @(negedge clock);
    req_valid = 3'b001;
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    req_valid = '1;
    #1 check("wrst_ready", 255'(req_ready), 255'd0);
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    m_ptr = 0; m_count = 0; m_err = 1'b0;
    check("wrst_busy", 255'(busy), 255'd0);
    check("wrst_valid", 255'(rsp_valid), 255'd0);
    check("wrst_mul_a", mul_a, 255'd0);
    check("wrst_count", 255'(op_count), 255'd0);
    check("wrst_err", 255'(err_spurious), 255'd0);
    set_ops(2, rnd255(), rnd255());
    do_op(3'b100, 1, 1, 1'b0, 255'd0, 1'b0);

    @(negedge clock);
    force dut.r_op_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_op_count;
    m_count = 65535;
    check("preload", 255'(op_count), 255'hFFFF);
    set_ops(1, rnd255(), rnd255());
    do_op(3'b010, 0, 0, 1'b0, 255'd0, 1'b0);
    check("wrap_zero", 255'(op_count), 255'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
